// File: rtl/sys_clk_pkg.sv
// ---------------------------------------------------------------------------
// sys_clk_pkg: shared state type, default constants and counter-width helper.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sys_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } sys_state_t;

  localparam int DEF_LOCK_STABLE = 1024;
  localparam int DEF_RST_CYCLES  = 16;
  localparam int DEF_CPU_DIV     = 4;
  localparam int DEF_PIX_DIV     = 2;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ce_div.sv
// ---------------------------------------------------------------------------
// ce_div: one-cycle clock-enable every DIV cycles while en is high.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ce_div
  import sys_clk_pkg::*;
#(
  parameter int DIV = DEF_CPU_DIV
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic ce
);

  if (DIV <= 1) begin : g_div1
    always_ff @(posedge clk) begin
      if (!resetn) ce <= 1'b0;
      else         ce <= en;
    end
  end else begin : g_divn
    localparam int             CW   = cnt_w(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // First pulse lands on the DIV-th enabled cycle, then every DIV cycles.
    always_ff @(posedge clk) begin
      if (!resetn || !en) begin
        cnt <= '0;
        ce  <= 1'b0;
      end else if (cnt == LAST) begin
        cnt <= '0;
        ce  <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
        ce  <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sys_reset_ce.sv
// ---------------------------------------------------------------------------
// sys_reset_ce: PLL lock qualification, system reset and CPU/pixel enables.
// Optional loss counter port: define SYS_LOCK_LOSS_CNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sys_reset_ce
  import sys_clk_pkg::*;
#(
  parameter int LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int CPU_DIV     = DEF_CPU_DIV,
  parameter int PIX_DIV     = DEF_PIX_DIV
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  output logic       sys_resetn,
  output logic       cpu_ce,
  output logic       pix_ce,
  output logic       lock_lost,
  output logic       run
`ifdef SYS_LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int                  CNT_W   = cnt_w((LOCK_STABLE > RST_CYCLES) ? LOCK_STABLE : RST_CYCLES);
  localparam logic [CNT_W-1:0]    LS_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0]    RC_LAST = CNT_W'(RST_CYCLES - 1);

  logic             sync1;
  logic             locked_s;
  sys_state_t       state;
  sys_state_t       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             drop;
  logic             run_nx;

  assign run_nx = (state_nx == RUN);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      state      <= WAIT_LOCK;
      cnt        <= '0;
      sys_resetn <= 1'b0;
      run        <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      sync1      <= pll_locked;
      locked_s   <= sync1;
      state      <= state_nx;
      cnt        <= cnt_nx;
      sys_resetn <= run_nx;
      run        <= run_nx;
      if (drop) lock_lost <= 1'b1;
    end
  end

  // Counter clears on every transition, so it never needs to wrap.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    drop     = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          if (cnt == LS_LAST) state_nx = HOLD;
          else                cnt_nx   = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!locked_s)            state_nx = WAIT_LOCK;
        else if (cnt == RC_LAST)  state_nx = RUN;
        else                      cnt_nx   = cnt + 1'b1;
      end
      RUN: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          drop     = 1'b1;
        end
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

`ifdef SYS_LOCK_LOSS_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn)                            lock_loss_cnt <= 8'd0;
    else if (drop && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`endif

  ce_div #(.DIV(CPU_DIV)) u_cpu_ce (
    .clk    (clk),
    .resetn (resetn),
    .en     (run_nx),
    .ce     (cpu_ce)
  );

  ce_div #(.DIV(PIX_DIV)) u_pix_ce (
    .clk    (clk),
    .resetn (resetn),
    .en     (run_nx),
    .ce     (pix_ce)
  );

endmodule

`default_nettype wire

// File: tb/tb_sys_reset_ce.sv
// ---------------------------------------------------------------------------
// tb_sys_reset_ce: directed + randomized bench with a streak-based lock model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sys_reset_ce;

  localparam int LS   = 8;
  localparam int RC   = 4;
  localparam int CD   = 4;
  localparam int PD   = 2;
  localparam int QUAL = LS + RC;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pll_locked = 1'b0;
  logic sys_resetn, cpu_ce, pix_ce, lock_lost, run;
`ifdef SYS_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  sys_reset_ce #(
    .LOCK_STABLE (LS),
    .RST_CYCLES  (RC),
    .CPU_DIV     (CD),
    .PIX_DIV     (PD)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .sys_resetn (sys_resetn),
    .cpu_ce     (cpu_ce),
    .pix_ce     (pix_ce),
    .lock_lost  (lock_lost),
    .run        (run)
`ifdef SYS_LOCK_LOSS_CNT_EN
    ,
    .lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the system runs once locked_s has been high for QUAL
  // consecutive edges; the run age then phases both enables.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  int   streak = 0;
  logic m_lost = 1'b0;
  int   m_cnt = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic pl);
    logic ls_old;
    logic was_run;
    logic e_run;
    int   age;
    resetn     = rn;
    pll_locked = pl;
    @(posedge clk);
    if (!rn) begin
      m_s1 = 1'b0; m_s2 = 1'b0; streak = 0; m_lost = 1'b0; m_cnt = 0;
    end else begin
      ls_old  = m_s2;
      m_s2    = m_s1;
      m_s1    = pl;
      was_run = (streak >= QUAL);
      if (ls_old) streak++;
      else begin
        if (was_run) begin
          m_lost = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
        streak = 0;
      end
    end
    #1;
    e_run = (streak >= QUAL);
    age   = streak - QUAL + 1;
    chk("sys_resetn", {7'd0, sys_resetn}, {7'd0, e_run});
    chk("run",        {7'd0, run},        {7'd0, e_run});
    chk("cpu_ce",     {7'd0, cpu_ce},     {7'd0, e_run && (age % CD == 0)});
    chk("pix_ce",     {7'd0, pix_ce},     {7'd0, e_run && (age % PD == 0)});
    chk("lock_lost",  {7'd0, lock_lost},  {7'd0, m_lost});
`ifdef SYS_LOCK_LOSS_CNT_EN
    chk("lock_loss_cnt", lock_loss_cnt, 8'(m_cnt));
`endif
  endtask

  // Steps with lock held high until sys_resetn rises; 0 means it never did.
  task automatic release_latency(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b1);
      if (sys_resetn === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int hi;
    int lo;

    // Power-up reset and clean lock
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    release_latency(lat);
    chk("powerup_latency", 8'(lat), 8'd14);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1);

    // Drop in RUN: outputs fall three cycles later, lock_lost sticks
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("run_drop_sysrst", {7'd0, sys_resetn}, 8'd0);
    chk("run_drop_lost", {7'd0, lock_lost}, 8'd1);

    // Glitch while waiting: qualification restarts from the final rise
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    release_latency(lat);
    chk("glitch_latency", 8'(lat), 8'd14);
    chk("lost_persists", {7'd0, lock_lost}, 8'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);

    // Drop during HOLD leaves reset asserted and lock_lost clear
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("hold_drop_sysrst", {7'd0, sys_resetn}, 8'd0);
    chk("hold_drop_lost", {7'd0, lock_lost}, 8'd0);

    // Mid-RUN block reset, then re-release with lock held high
    release_latency(lat);
    chk("hold_retry_latency", 8'(lat), 8'd14);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("midrun_rst_run", {7'd0, run}, 8'd0);
    release_latency(lat);
    chk("midrun_latency", 8'(lat), 8'd14);

    // Randomized lock bursts with occasional block resets
    for (int b = 0; b < 60; b++) begin
      hi = $urandom_range(1, 30);
      lo = $urandom_range(1, 3);
      for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
      for (int i = 0; i < lo; i++) step(1'b1, 1'b0);
      if ($urandom_range(0, 9) == 0) step(1'b0, 1'($urandom_range(0, 1)));
    end

`ifdef SYS_LOCK_LOSS_CNT_EN
    // Saturation of the loss counter
    step(1'b0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < QUAL + 4; i++) step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
    end
    chk("loss_cnt_saturated", lock_loss_cnt, 8'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
